// File: rtl/systolic_fir_filter_ntap.sv
`default_nettype none
// ============================================================================
// Module   : systolic_fir_filter_ntap
// Function : TAPS-stage systolic FIR with runtime-loadable weights, valid-tagged
//            samples, and an arithmetically shifted, saturating output.
// Revision : 1.0
// ============================================================================
module systolic_fir_filter_ntap #(
    parameter int TAPS      = 8,
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 32,
    parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     coef_start,
    input  logic                     coef_valid,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     x_valid,
    input  logic signed [DATA_W-1:0] x,
    output logic                     x_ready,
    output logic                     y_valid,
    output logic signed [DATA_W-1:0] y,
    output logic                     sat_flag,
    output logic                     loading
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CNT_W  = $clog2(TAPS);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [CNT_W-1:0]           r_count;
    logic                       w_wr;
    logic                       w_adv;
    logic signed [DATA_W-1:0]   r_xin;
    logic                       r_vin;
    logic [TAPS-1:0]            r_v;
    logic signed [DATA_W-1:0]   w_s     [TAPS];
    logic signed [ACC_W-1:0]    w_psum  [TAPS];
    logic signed [ACC_W-1:0]    w_shift;
    logic                       w_ovf_hi;
    logic                       w_ovf_lo;
    logic signed [DATA_W-1:0]   w_sat_y;

    always_comb begin
        w_state_next = r_state;
        w_wr         = 1'b0;
        loading      = 1'b0;
        x_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (coef_start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                loading = 1'b1;
                if (coef_start) begin
                    w_state_next = S_LOAD;
                end else if (coef_valid) begin
                    w_wr = 1'b1;
                    if (r_count == c_last) w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                x_ready = 1'b1;
                if (coef_start) w_state_next = S_LOAD;
            end
            default: w_state_next = S_IDLE;
        endcase
        // The array only moves in RUN; any other cycle (including the one that
        // leaves RUN) flushes it so the next run starts from zero history.
        w_adv = (r_state == S_RUN) && !coef_start;
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (coef_start) begin
                r_count <= '0;
            end else if (w_wr) begin
                r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN || !w_adv) begin
            r_xin <= '0;
            r_vin <= 1'b0;
            r_v   <= '0;
        end else begin
            r_xin <= x_valid ? x : '0;
            r_vin <= x_valid;
            r_v   <= {r_v[TAPS-2:0], r_vin};
        end
    end

    assign w_s[0] = r_xin;

    generate
        for (genvar k = 0; k < TAPS; k++) begin : g_pe
            logic signed [COEF_W-1:0] r_w;
            logic signed [ACC_W-1:0]  r_p;
            logic signed [PROD_W-1:0] w_prod;

            assign w_prod    = PROD_W'(r_w) * PROD_W'(w_s[k]);
            assign w_psum[k] = r_p;

            always_ff @(posedge clock) begin
                if (!resetN) begin
                    r_w <= '0;
                end else if (w_wr && (r_count == CNT_W'(k))) begin
                    r_w <= coef_data;
                end
            end

            if (k == 0) begin : g_first
                always_ff @(posedge clock) begin
                    if (!resetN || !w_adv) r_p <= '0;
                    else                   r_p <= ACC_W'(w_prod);
                end
            end else begin : g_chain
                always_ff @(posedge clock) begin
                    if (!resetN || !w_adv) r_p <= '0;
                    else                   r_p <= w_psum[k-1] + ACC_W'(w_prod);
                end
            end

            // Samples move two stages per PE against one for the sums, which
            // staggers each tap by exactly one sample.
            if (k < TAPS - 1) begin : g_delay
                logic signed [DATA_W-1:0] r_xa;
                logic signed [DATA_W-1:0] r_xb;
                always_ff @(posedge clock) begin
                    if (!resetN || !w_adv) begin
                        r_xa <= '0;
                        r_xb <= '0;
                    end else begin
                        r_xa <= w_s[k];
                        r_xb <= r_xa;
                    end
                end
                assign w_s[k+1] = r_xb;
            end
        end
    endgenerate

    assign w_shift  = w_psum[TAPS-1] >>> OUT_SHIFT;
    assign w_ovf_hi = w_shift > c_sat_max;
    assign w_ovf_lo = w_shift < c_sat_min;
    assign w_sat_y  = w_ovf_hi ? c_sat_max[DATA_W-1:0] :
                      w_ovf_lo ? c_sat_min[DATA_W-1:0] : w_shift[DATA_W-1:0];

    always_ff @(posedge clock) begin
        if (!resetN || !w_adv) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y       <= w_sat_y;
            y_valid <= r_v[TAPS-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN || coef_start) begin
            sat_flag <= 1'b0;
        end else if (w_adv && r_v[TAPS-1] && (w_ovf_hi || w_ovf_lo)) begin
            sat_flag <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_fir_filter_ntap.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_fir_filter_ntap
// Function : Directed bench for systolic_fir_filter_ntap (TAPS=4, 16-bit data).
// Revision : 1.0
// ============================================================================
module tb_systolic_fir_filter_ntap;

    logic               clock;
    logic               resetN;
    logic               coef_start;
    logic               coef_valid;
    logic signed [15:0] coef_data;
    logic               x_valid;
    logic signed [15:0] x;
    logic               x_ready,  y_valid,  sat_flag,  loading;
    logic signed [15:0] y;
    logic               x_ready2, y_valid2, sat_flag2, loading2;
    logic signed [15:0] y2;

    int n_checks = 0;
    int n_fail   = 0;

    int stim_x [32];
    bit stim_v [32];
    int obs_y  [32];
    int obs_y2 [32];
    bit obs_v  [32];
    bit obs_sat[32];
    bit ld_loading[5];
    bit ld_xready [5];
    bit ld_yv     [5];
    bit ld_sat    [5];

    systolic_fir_filter_ntap #(.TAPS(4), .DATA_W(16), .COEF_W(16), .OUT_SHIFT(0)) u_dut (
        .clock(clock), .resetN(resetN), .coef_start(coef_start), .coef_valid(coef_valid),
        .coef_data(coef_data), .x_valid(x_valid), .x(x), .x_ready(x_ready),
        .y_valid(y_valid), .y(y), .sat_flag(sat_flag), .loading(loading)
    );

    systolic_fir_filter_ntap #(.TAPS(4), .DATA_W(16), .COEF_W(16), .OUT_SHIFT(2)) u_dut_sh (
        .clock(clock), .resetN(resetN), .coef_start(coef_start), .coef_valid(coef_valid),
        .coef_data(coef_data), .x_valid(x_valid), .x(x), .x_ready(x_ready2),
        .y_valid(y_valid2), .y(y2), .sat_flag(sat_flag2), .loading(loading2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        int w[4];
        w = '{a, b, c, d};
        coef_start = 1'b1;
        coef_valid = 1'b0;
        tick();
        ld_loading[0] = loading; ld_xready[0] = x_ready; ld_yv[0] = y_valid; ld_sat[0] = sat_flag;
        coef_start = 1'b0;
        coef_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            coef_data = 16'(w[i]);
            tick();
            ld_loading[i+1] = loading; ld_xready[i+1] = x_ready;
            ld_yv[i+1] = y_valid; ld_sat[i+1] = sat_flag;
        end
        coef_valid = 1'b0;
    endtask

    // Output for sample s shows up in obs[s+5].
    task automatic drive(input int n);
        for (int c = 0; c < n; c++) begin
            x_valid = stim_v[c];
            x       = stim_v[c] ? 16'(stim_x[c]) : 16'sd77;
            tick();
            obs_y[c] = int'(y); obs_y2[c] = int'(y2);
            obs_v[c] = y_valid; obs_sat[c] = sat_flag;
        end
        x_valid = 1'b0;
        x       = '0;
    endtask

    task automatic test_reset();
        resetN = 1'b0; coef_start = 1'b0; coef_valid = 1'b0; coef_data = '0;
        x_valid = 1'b0; x = '0;
        tick(); tick();
        n_checks++; if (y !== 16'sd0)   begin n_fail++; $display("FAIL reset_y: got %0d expected 0", y); end
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
        n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL reset_x_ready: got %b expected 0", x_ready); end
        n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", sat_flag); end
        n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL reset_loading: got %b expected 0", loading); end
        resetN = 1'b1;
        coef_valid = 1'b1; coef_data = 16'sd9;
        tick(); tick(); tick();
        coef_valid = 1'b0;
        n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL idle_valid_loading: got %b expected 0", loading); end
        n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL idle_valid_x_ready: got %b expected 0", x_ready); end
    endtask

    task automatic test_impulse(input string tag);
        int ey[7];
        ey = '{1, 2, 3, 4, 0, 0, 0};
        load4(1, 2, 3, 4);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (ld_loading[i] !== 1'b1) begin n_fail++; $display("FAIL %s_loading[%0d]: got %b expected 1", tag, i, ld_loading[i]); end
        end
        n_checks++; if (ld_xready[3] !== 1'b0) begin n_fail++; $display("FAIL %s_x_ready_early: got %b expected 0", tag, ld_xready[3]); end
        n_checks++; if (ld_xready[4] !== 1'b1) begin n_fail++; $display("FAIL %s_x_ready_run: got %b expected 1", tag, ld_xready[4]); end
        n_checks++; if (ld_loading[4] !== 1'b0) begin n_fail++; $display("FAIL %s_loading_run: got %b expected 0", tag, ld_loading[4]); end
        for (int c = 0; c < 12; c++) begin stim_v[c] = 1'b1; stim_x[c] = (c == 0) ? 1 : 0; end
        drive(12);
        for (int j = 0; j < 5; j++) begin
            n_checks++; if (obs_v[j] !== 1'b0) begin n_fail++; $display("FAIL %s_pre_valid[%0d]: got %b expected 0", tag, j, obs_v[j]); end
        end
        for (int s = 0; s < 7; s++) begin
            n_checks++; if (obs_v[s+5] !== 1'b1) begin n_fail++; $display("FAIL %s_valid[%0d]: got %b expected 1", tag, s, obs_v[s+5]); end
            n_checks++; if (obs_y[s+5] !== ey[s]) begin n_fail++; $display("FAIL %s_y[%0d]: got %0d expected %0d", tag, s, obs_y[s+5], ey[s]); end
        end
    endtask

    task automatic test_step();
        int e1[6], e2[6], e2s[6], e3[5], e3s[5];
        e1 = '{1, 2, 3, 4, 4, 4};
        e2 = '{1, 3, 6, 10, 10, 10};
        e2s = '{0, 0, 1, 2, 2, 2};
        e3 = '{-3, -9, -18, -30, -30};
        e3s = '{-1, -3, -5, -8, -8};
        load4(1, 1, 1, 1);
        for (int c = 0; c < 11; c++) begin stim_v[c] = 1'b1; stim_x[c] = 1; end
        drive(11);
        for (int s = 0; s < 6; s++) begin
            n_checks++; if (obs_y[s+5] !== e1[s]) begin n_fail++; $display("FAIL step_ones_y[%0d]: got %0d expected %0d", s, obs_y[s+5], e1[s]); end
        end
        load4(1, 2, 3, 4);
        drive(11);
        for (int s = 0; s < 6; s++) begin
            n_checks++; if (obs_y[s+5] !== e2[s]) begin n_fail++; $display("FAIL step_ramp_y[%0d]: got %0d expected %0d", s, obs_y[s+5], e2[s]); end
            n_checks++; if (obs_y2[s+5] !== e2s[s]) begin n_fail++; $display("FAIL step_shift_y[%0d]: got %0d expected %0d", s, obs_y2[s+5], e2s[s]); end
        end
        load4(1, 2, 3, 4);
        for (int c = 0; c < 10; c++) begin stim_v[c] = 1'b1; stim_x[c] = -3; end
        drive(10);
        for (int s = 0; s < 5; s++) begin
            n_checks++; if (obs_y[s+5] !== e3[s]) begin n_fail++; $display("FAIL step_neg_y[%0d]: got %0d expected %0d", s, obs_y[s+5], e3[s]); end
            n_checks++; if (obs_y2[s+5] !== e3s[s]) begin n_fail++; $display("FAIL step_neg_shift_y[%0d]: got %0d expected %0d", s, obs_y2[s+5], e3s[s]); end
        end
    endtask

    task automatic test_gaps();
        int ey[9];
        ey = '{5, 0, 10, 0, 10, 0, 10, 0, 10};
        load4(1, 1, 1, 1);
        coef_valid = 1'b1; coef_data = 16'sd100;
        for (int c = 0; c < 14; c++) begin stim_v[c] = (c % 2 == 0); stim_x[c] = 5; end
        drive(14);
        coef_valid = 1'b0;
        for (int s = 0; s < 9; s++) begin
            n_checks++; if (obs_v[s+5] !== bit'(s % 2 == 0)) begin n_fail++; $display("FAIL gaps_valid[%0d]: got %b expected %b", s, obs_v[s+5], (s % 2 == 0)); end
            if (s % 2 == 0) begin
                n_checks++; if (obs_y[s+5] !== ey[s]) begin n_fail++; $display("FAIL gaps_y[%0d]: got %0d expected %0d", s, obs_y[s+5], ey[s]); end
            end
        end
        n_checks++; if (x_ready !== 1'b1) begin n_fail++; $display("FAIL gaps_run_kept: got %b expected 1", x_ready); end
    endtask

    task automatic test_saturation();
        load4(32767, 32767, 32767, 32767);
        for (int c = 0; c < 7; c++) begin stim_v[c] = 1'b1; stim_x[c] = 32767; end
        drive(7);
        n_checks++; if (obs_sat[4] !== 1'b0) begin n_fail++; $display("FAIL sat_pos_early: got %b expected 0", obs_sat[4]); end
        n_checks++; if (obs_y[5] !== 32767) begin n_fail++; $display("FAIL sat_pos_y: got %0d expected 32767", obs_y[5]); end
        n_checks++; if (obs_sat[5] !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag: got %b expected 1", obs_sat[5]); end
        load4(32767, 32767, 32767, 32767);
        n_checks++; if (ld_sat[0] !== 1'b0) begin n_fail++; $display("FAIL sat_cleared: got %b expected 0", ld_sat[0]); end
        for (int c = 0; c < 7; c++) begin stim_v[c] = 1'b1; stim_x[c] = -32768; end
        drive(7);
        n_checks++; if (obs_sat[4] !== 1'b0) begin n_fail++; $display("FAIL sat_neg_early: got %b expected 0", obs_sat[4]); end
        n_checks++; if (obs_y[5] !== -32768) begin n_fail++; $display("FAIL sat_neg_y: got %0d expected -32768", obs_y[5]); end
        n_checks++; if (obs_sat[5] !== 1'b1) begin n_fail++; $display("FAIL sat_neg_flag: got %b expected 1", obs_sat[5]); end
    endtask

    task automatic test_reload();
        int w[4];
        int ey[5];
        w  = '{2, 0, 0, 0};
        ey = '{6, -8, 14, 2, 4};
        for (int c = 0; c < 3; c++) begin stim_v[c] = 1'b1; stim_x[c] = 100; end
        drive(3);
        x_valid = 1'b1; x = 16'sd50;
        coef_start = 1'b1; coef_valid = 1'b1; coef_data = 16'sd99;
        tick();
        coef_start = 1'b0;
        n_checks++; if (loading !== 1'b1) begin n_fail++; $display("FAIL reload_loading_start: got %b expected 1", loading); end
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reload_y_valid_start: got %b expected 0", y_valid); end
        n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reload_sat_cleared: got %b expected 0", sat_flag); end
        for (int i = 0; i < 4; i++) begin
            coef_data = 16'(w[i]);
            tick();
            n_checks++; if (loading !== bit'(i < 3)) begin n_fail++; $display("FAIL reload_loading[%0d]: got %b expected %b", i, loading, (i < 3)); end
            n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reload_y_valid[%0d]: got %b expected 0", i, y_valid); end
        end
        coef_valid = 1'b0;
        n_checks++; if (x_ready !== 1'b1) begin n_fail++; $display("FAIL reload_x_ready: got %b expected 1", x_ready); end
        stim_x[0] = 3; stim_x[1] = -4; stim_x[2] = 7; stim_x[3] = 1; stim_x[4] = 2;
        for (int c = 0; c < 10; c++) begin
            stim_v[c] = 1'b1;
            if (c > 4) stim_x[c] = 0;
        end
        drive(10);
        for (int j = 0; j < 5; j++) begin
            n_checks++; if (obs_v[j] !== 1'b0) begin n_fail++; $display("FAIL reload_history_valid[%0d]: got %b expected 0", j, obs_v[j]); end
        end
        for (int s = 0; s < 5; s++) begin
            n_checks++; if (obs_y[s+5] !== ey[s]) begin n_fail++; $display("FAIL reload_y[%0d]: got %0d expected %0d", s, obs_y[s+5], ey[s]); end
        end
    endtask

    task automatic test_reset_midload();
        coef_start = 1'b1; tick(); coef_start = 1'b0;
        coef_valid = 1'b1; coef_data = 16'sd5; tick();
        coef_data = 16'sd6; tick();
        coef_valid = 1'b0;
        resetN = 1'b0;
        tick();
        n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL midload_loading: got %b expected 0", loading); end
        n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL midload_x_ready: got %b expected 0", x_ready); end
        n_checks++; if (y !== 16'sd0) begin n_fail++; $display("FAIL midload_y: got %0d expected 0", y); end
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL midload_y_valid: got %b expected 0", y_valid); end
        n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL midload_sat: got %b expected 0", sat_flag); end
        resetN = 1'b1;
        tick();
        n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL midload_idle_x_ready: got %b expected 0", x_ready); end
        test_impulse("post_reset");
    endtask

    initial begin
        test_reset();
        test_impulse("impulse");
        test_step();
        test_gaps();
        test_saturation();
        test_reload();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_fir_filter_ntap.md
# systolic_fir_filter_ntap

Parametrised systolic FIR filter, the successor to the fixed 4-tap systolic filter, with runtime-loadable coefficients, a valid-qualified sample stream, and saturating, scaled output. It is a linear chain of TAPS processing elements, each holding one weight, with a double-registered sample path and a single-registered partial-sum path. It sits in the filter library between a sample source (ADC front end or testbench stream) and downstream fixed-point consumers, carrying signed two's-complement data.

## Interface
- TAPS, 8: number of PEs/coefficients; ≥2.
- DATA_W, 32: sample and output width, signed.
- COEF_W, 32: coefficient width, signed.
- ACC_W, DATA_W+COEF_W+$clog2(TAPS): partial-sum width, signed.
- OUT_SHIFT, 0: arithmetic right shift applied to the final sum before saturation.
- clock  in  1  system clock; all logic on posedge.
- resetN  in  1  reset, synchronous, active-low.
- coef_start  in  1  one-cycle pulse that begins a coefficient (re)load.
- coef_valid  in  1  coef_data is valid this cycle.
- coef_data  in  COEF_W  coefficient; w0 first, w(TAPS-1) last.
- x_valid  in  1  x carries a sample this cycle.
- x  in  DATA_W  input sample.
- x_ready  out  1  high only in RUN.
- y_valid  out  1  y carries a filtered sample.
- y  out  DATA_W  filter output.
- sat_flag  out  1  sticky: output saturation occurred since the last reset or coef_start.
- loading  out  1  high in LOAD.

## Operation
- States: IDLE, LOAD, RUN. Reset → IDLE.
- Reset clears all weights, sample and partial-sum registers, the coefficient counter, y, y_valid and sat_flag.
- IDLE → LOAD on coef_start. RUN → LOAD on coef_start.
- coef_start in LOAD restarts the count at 0. Weights already written are kept until overwritten.
- Entering LOAD clears sat_flag and every sample and partial-sum register, and drops y_valid.
- LOAD: each cycle with coef_valid=1 writes coef_data to weight[count] and increments count.
- On the write of index TAPS-1 → RUN in the next cycle.
- coef_valid without a preceding coef_start is ignored (IDLE or RUN).
- coef_start and coef_valid in the same cycle: coef_start wins; that coef_data is not written.
- In LOAD and IDLE, x and x_valid are ignored, and y_valid=0.
- RUN: the array advances every cycle.
  - A cycle with x_valid=0 injects a zero sample.
  - Output sequence: y[n] = sat(( Σ_k w_k·x[n−k] ) >>> OUT_SHIFT), where x is the injected stream (zeros included).
  - A valid tag travels with each sample; y_valid is the x_valid of the sample whose output y is.
- Arithmetic:
  - Products are full width, DATA_W+COEF_W.
  - Sums are ACC_W and cannot overflow internally.
  - The shift is arithmetic (floor).
  - Saturation clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and sets sat_flag, but only when y_valid is asserted.
- Reset during LOAD or RUN: behaves as power-on reset, returning to IDLE with weights zero.

## Timing
- Reset values: y=0, y_valid=0, x_ready=0, sat_flag=0, loading=0.
- Coefficient load takes exactly TAPS accepted coef_valid cycles. x_ready rises the cycle after the last write.
- Latency: a sample presented with x_valid=1 at posedge t produces its y/y_valid at the output register after posedge t+TAPS+1.
- Throughput: one sample per cycle; no backpressure in RUN.
- Each output includes only samples accepted since entering RUN. Earlier history is zero.
- sat_flag is set at the same edge as the saturated y and stays high until reset or coef_start.

## Test plan
- Impulse, TAPS=4, OUT_SHIFT=0:
  - Reset, coef_start, load 1,2,3,4.
  - Then x=1 for one valid cycle, followed by x_valid=1 with x=0.
  - Required: y=1,2,3,4 on consecutive cycles starting TAPS+1 cycles after the impulse, then 0; y_valid high throughout.
- Step, TAPS=4, weights 1,1,1,1, x=1 every cycle:
  - Required: y=1,2,3,4,4,4…
  - Repeat with weights 1,2,3,4: required y=1,3,6,10,10…
- Gaps, TAPS=4, weights 1,1,1,1:
  - x_valid pattern 1,0,1,0 with x=5.
  - Required: y_valid pattern 1,0,1,0 delayed by 5 cycles; y on valid cycles 5,10,10…
- Saturation, DATA_W=16:
  - Weights all 0x7FFF, x=0x7FFF.
  - Required: y=32767 and sat_flag=1.
  - Then coef_start: required sat_flag=0.
  - Negative case, x=−32768: required y=−32768.
- Reload mid-run:
  - In RUN, pulse coef_start and load 2,0,0,0.
  - Required: loading=1 and y_valid=0 during load; after RUN, y=2·x with zero history.
  - Also: a coef_valid in the same cycle as coef_start is not written.
- Reset mid-load:
  - Assert resetN=0 after 2 of 4 coefficients.
  - Required: IDLE, all outputs 0, x_ready=0.
  - After a full reload, outputs match the impulse test.
